memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
Single-port AXI4-Lite master that arbitrates between the rv32i core's instruction-fetch path and its load/store path. It serialises requests onto one AXI4-Lite interface, with one outstanding transaction at a time. It returns fetched instructions and load data with one-cycle valid pulses. It sits between the pipeline front-end/LSU and the system interconnect.

Parameters:
- ADDR_WIDTH, 32: AXI address width (`C_AXI_ADDR_WIDTH`).
- DATA_WIDTH, 32: AXI data, instruction and load/store data width (`C_AXI_DATA_WIDTH`, `DATA_WIDTH`, `INSTR_WIDTH`).
- STRB_WIDTH, DATA_WIDTH/8: write strobe width (`C_AXI_STROBE_WIDTH`).

Ports:
CLK in 1 system clock, all logic on rising edge
RSTn in 1 reset; one clock, synchronous, active-low
M_AXI_AWVALID out 1 write address valid
M_AXI_AWREADY in 1 write address ready
M_AXI_AWADDR out ADDR_WIDTH write address
M_AXI_AWPROT out 3 fixed 3'b000
M_AXI_WVALID out 1 write data valid
M_AXI_WREADY in 1 write data ready
M_AXI_WDATA out DATA_WIDTH write data
M_AXI_WSTRB out STRB_WIDTH byte strobes
M_AXI_BVALID in 1 write response valid
M_AXI_BREADY out 1 write response ready
M_AXI_BRESP in 2 write response (ignored)
M_AXI_ARVALID out 1 read address valid
M_AXI_ARREADY in 1 read address ready
M_AXI_ARADDR out ADDR_WIDTH read address
M_AXI_ARPROT out 3 read protection (see Optional Feature)
M_AXI_RVALID in 1 read data valid
M_AXI_RREADY out 1 read data ready
M_AXI_RDATA in DATA_WIDTH read data
M_AXI_RRESP in 2 read response (ignored)
pc in DATA_WIDTH fetch address
pc_valid in 1 fetch request, level
instruction out DATA_WIDTH fetched word, registered
instruction_valid out 1 one-cycle pulse, instruction valid
addr in DATA_WIDTH load/store address
write_data in DATA_WIDTH store data
read_data out DATA_WIDTH load result, registered
read_enable in 1 load request, level
write_enable in 1 store request, level
write_strobe in STRB_WIDTH store byte enables
operation_valid out 1 one-cycle pulse, load/store complete

Behaviour:
- All outputs are registered. In reset, every output is 0 and the FSM is in IDLE. Reset mid-transaction aborts immediately; a whole-system reset is assumed.
- FSM states: IDLE, F_AR, F_R, L_AR, L_R, S_AW_W, S_B.
- IDLE priority on each edge: write_enable → S_AW_W; else read_enable → L_AR; else pc_valid → F_AR. Load/store beats fetch. If write_enable and read_enable are both high, the store wins.
- Latch addresses and data on IDLE exit and hold them stable while VALID is high: ARADDR=pc or addr, AWADDR=addr, WDATA=write_data, WSTRB=write_strobe.
- F_AR / L_AR: ARVALID=1 from the first cycle of the state. On the ARVALID&ARREADY edge: ARVALID←0, RREADY←1, next state F_R / L_R.
- F_R / L_R: on the RVALID&RREADY edge: RREADY←0, result captured, next state IDLE.
  - F_R: instruction←RDATA, instruction_valid←1.
  - L_R: read_data←RDATA, operation_valid←1.
- S_AW_W: AWVALID=1 and WVALID=1 together. Each drops independently after its own handshake, in either order or the same cycle. When both are done: BREADY←1, next state S_B.
- S_B: on the BVALID&BREADY edge: BREADY←0, operation_valid←1, next state IDLE.
- instruction_valid and operation_valid are high for exactly one cycle. instruction and read_data hold their value until the next capture.
- Latency, pc_valid sampled to ARVALID: 1 cycle. ARREADY is checked the same cycle ARVALID is high.
- Requesters must drop or replace their request in the cycle the done pulse is seen. A request still high on the following edge starts a new transaction.
- Request inputs are ignored while not in IDLE.
- BRESP/RRESP are not checked; errors are treated as OKAY.

Optional Feature:
- Macro: MEMORY_ARBITER_INSTR_PROT_EN.
- Defined: M_AXI_ARPROT=3'b100 for fetches (instruction access) and 3'b000 for loads.
- Undefined: M_AXI_ARPROT=3'b000 always.
- M_AXI_AWPROT=3'b000 in both cases.

Test Plan:
- Reset: hold RSTn=0 for 2 cycles → ARVALID=AWVALID=WVALID=0, instruction_valid=operation_valid=0.
- Fetch: pc=32'habac, pc_valid=1 → ARVALID=1, ARADDR=32'habac within 2 edges. ARREADY=1 for 1 cycle → ARVALID=0, RREADY=1. RVALID=1, RDATA=32'hdeadaaaa → next cycle RREADY=0, instruction_valid=1 for 1 cycle, instruction=32'hdeadaaaa.
- Load: addr=32'h100, read_enable=1, RDATA=32'h12345678 → ARADDR=32'h100, read_data=32'h12345678, single operation_valid pulse.
- Store with skewed ready: addr=32'h200, write_data=32'h0badf00d, write_strobe=4'b0011. WREADY asserted 2 cycles before AWREADY → WVALID drops first, AWVALID holds. After BVALID: BREADY handshake, then one operation_valid pulse.
- Contention: pc_valid and read_enable rise the same cycle → load issues first; fetch issues after operation_valid.
- Stall: ARREADY held 0 for 5 cycles → ARVALID and ARADDR stay stable, no valid pulses. Reset mid-read → all outputs return to 0.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter: AXI4-Lite master serialising rv32i instruction fetches and load/stores.
// Define MEMORY_ARBITER_INSTR_PROT_EN to tag fetches as instruction accesses on ARPROT.
module memory_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]            M_AXI_AWPROT,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [STRB_WIDTH-1:0] M_AXI_WSTRB,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    input  logic [1:0]            M_AXI_BRESP,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]            M_AXI_ARPROT,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY,
    input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic                  pc_valid,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic                  instruction_valid,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic                  read_enable,
    input  logic                  write_enable,
    input  logic [STRB_WIDTH-1:0] write_strobe,
    output logic                  operation_valid
);
`ifdef MEMORY_ARBITER_INSTR_PROT_EN
    localparam logic [2:0] FETCH_PROT = 3'b100;
`else
    localparam logic [2:0] FETCH_PROT = 3'b000;
`endif

    typedef enum logic [2:0] {IDLE, F_AR, F_R, L_AR, L_R, S_AW_W, S_B} state_t;

    state_t state;
    logic   aw_done;
    logic   w_done;
    logic   unused_resp;

    // Responses are treated as OKAY regardless of their code.
    assign unused_resp  = ^{M_AXI_BRESP, M_AXI_RRESP};
    assign M_AXI_AWPROT = 3'b000;
    assign aw_done      = !M_AXI_AWVALID || M_AXI_AWREADY;
    assign w_done       = !M_AXI_WVALID || M_AXI_WREADY;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state             <= IDLE;
            M_AXI_AWVALID     <= 1'b0;
            M_AXI_AWADDR      <= '0;
            M_AXI_WVALID      <= 1'b0;
            M_AXI_WDATA       <= '0;
            M_AXI_WSTRB       <= '0;
            M_AXI_BREADY      <= 1'b0;
            M_AXI_ARVALID     <= 1'b0;
            M_AXI_ARADDR      <= '0;
            M_AXI_ARPROT      <= 3'b000;
            M_AXI_RREADY      <= 1'b0;
            instruction       <= '0;
            instruction_valid <= 1'b0;
            read_data         <= '0;
            operation_valid   <= 1'b0;
        end else begin
            instruction_valid <= 1'b0;
            operation_valid   <= 1'b0;
            case (state)
                IDLE: begin
                    if (write_enable) begin
                        M_AXI_AWADDR  <= ADDR_WIDTH'(addr);
                        M_AXI_WDATA   <= write_data;
                        M_AXI_WSTRB   <= write_strobe;
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                        state         <= S_AW_W;
                    end else if (read_enable) begin
                        M_AXI_ARADDR  <= ADDR_WIDTH'(addr);
                        M_AXI_ARPROT  <= 3'b000;
                        M_AXI_ARVALID <= 1'b1;
                        state         <= L_AR;
                    end else if (pc_valid) begin
                        M_AXI_ARADDR  <= ADDR_WIDTH'(pc);
                        M_AXI_ARPROT  <= FETCH_PROT;
                        M_AXI_ARVALID <= 1'b1;
                        state         <= F_AR;
                    end
                end
                F_AR, L_AR: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= (state == F_AR) ? F_R : L_R;
                    end
                end
                F_R: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY      <= 1'b0;
                        instruction       <= M_AXI_RDATA;
                        instruction_valid <= 1'b1;
                        state             <= IDLE;
                    end
                end
                L_R: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY    <= 1'b0;
                        read_data       <= M_AXI_RDATA;
                        operation_valid <= 1'b1;
                        state           <= IDLE;
                    end
                end
                S_AW_W: begin
                    // Address and data channels complete independently, in either order.
                    if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WREADY) M_AXI_WVALID <= 1'b0;
                    if (aw_done && w_done) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= S_B;
                    end
                end
                S_B: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY    <= 1'b0;
                        operation_valid <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: scoreboard bench with a responsive AXI4-Lite slave model.
module tb_memory_arbiter;
`ifdef MEMORY_ARBITER_INSTR_PROT_EN
    localparam logic [2:0] FPROT = 3'b100;
`else
    localparam logic [2:0] FPROT = 3'b000;
`endif
    localparam int QAR = 0, QAW = 1, QW = 2, QINS = 3, QOP = 4;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        M_AXI_AWVALID, M_AXI_AWREADY = 1'b0;
    logic [31:0] M_AXI_AWADDR;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_WVALID, M_AXI_WREADY = 1'b0;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_BVALID = 1'b0, M_AXI_BREADY;
    logic [1:0]  M_AXI_BRESP = 2'b00;
    logic        M_AXI_ARVALID, M_AXI_ARREADY = 1'b0;
    logic [31:0] M_AXI_ARADDR;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_RVALID = 1'b0, M_AXI_RREADY;
    logic [31:0] M_AXI_RDATA = '0;
    logic [1:0]  M_AXI_RRESP = 2'b00;
    logic [31:0] pc = '0, addr = '0, write_data = '0;
    logic        pc_valid = 1'b0, read_enable = 1'b0, write_enable = 1'b0;
    logic [3:0]  write_strobe = '0;
    logic [31:0] instruction, read_data;
    logic        instruction_valid, operation_valid;

    logic [63:0] sb [5][$];
    string       qname [5] = '{"ar", "aw", "w", "instr", "op"};
    int          checks = 0, failures = 0;
    int          ar_delay = 0, aw_delay = 0, w_delay = 0;
    int          arw = 0, aww = 0, ww = 0;
    bit          r_stall = 1'b0;

    memory_arbiter dut (
        .CLK(CLK), .RSTn(RSTn),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BRESP(M_AXI_BRESP),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .pc(pc), .pc_valid(pc_valid), .instruction(instruction),
        .instruction_valid(instruction_valid), .addr(addr), .write_data(write_data),
        .read_data(read_data), .read_enable(read_enable), .write_enable(write_enable),
        .write_strobe(write_strobe), .operation_valid(operation_valid)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'habac) ? 32'hdeadaaaa : (a == 32'h100) ? 32'h12345678 : a ^ 32'hc0de0000;
    endfunction

    function automatic int total();
        return sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() + sb[4].size();
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic pop(input int k, input logic [63:0] act);
        if (sb[k].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: unexpected output %h", qname[k], act);
        end else check(qname[k], act, sb[k].pop_front());
    endtask

    // Monitor: every handshake or done pulse is matched against the scoreboard.
    initial forever begin
        @(negedge CLK);
        if (M_AXI_ARVALID && M_AXI_ARREADY) pop(QAR, {29'd0, M_AXI_ARPROT, M_AXI_ARADDR});
        if (M_AXI_AWVALID && M_AXI_AWREADY) pop(QAW, {29'd0, M_AXI_AWPROT, M_AXI_AWADDR});
        if (M_AXI_WVALID && M_AXI_WREADY) pop(QW, {28'd0, M_AXI_WSTRB, M_AXI_WDATA});
        if (instruction_valid) pop(QINS, {32'd0, instruction});
        if (operation_valid) pop(QOP, {32'd0, read_data});
    end

    // Slave: ready after a programmable number of valid cycles; R/B answer immediately.
    initial forever begin
        @(posedge CLK);
        #1;
        arw = M_AXI_ARVALID ? arw + 1 : 0;
        aww = M_AXI_AWVALID ? aww + 1 : 0;
        ww  = M_AXI_WVALID ? ww + 1 : 0;
        M_AXI_ARREADY = M_AXI_ARVALID && arw > ar_delay;
        M_AXI_AWREADY = M_AXI_AWVALID && aww > aw_delay;
        M_AXI_WREADY  = M_AXI_WVALID && ww > w_delay;
        M_AXI_RVALID  = M_AXI_RREADY && !r_stall;
        M_AXI_RDATA   = M_AXI_RVALID ? mem(M_AXI_ARADDR) : '0;
        M_AXI_BVALID  = M_AXI_BREADY;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic issue(input logic we, input logic re, input logic pv, input logic [31:0] a,
                         input logic [31:0] p, input logic [31:0] wd, input logic [3:0] st);
        addr = a;
        pc = p;
        write_data = wd;
        write_strobe = st;
        write_enable = we;
        read_enable = re;
        pc_valid = pv;
        @(posedge CLK);
        #1;
        write_enable = 1'b0;
        read_enable = 1'b0;
        pc_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && total() != 0; i++) @(negedge CLK);
        check({"drain_", name}, 64'(total()), 64'd0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_arvalid", M_AXI_ARVALID, 1'b0);
        check("reset_awvalid", M_AXI_AWVALID, 1'b0);
        check("reset_wvalid", M_AXI_WVALID, 1'b0);
        check("reset_instr_valid", instruction_valid, 1'b0);
        check("reset_op_valid", operation_valid, 1'b0);
        check("reset_ready", {M_AXI_RREADY, M_AXI_BREADY}, 2'b00);
        @(posedge CLK);
        #1;
        RSTn = 1'b1;

        sb[QAR].push_back({29'd0, FPROT, 32'habac});
        sb[QINS].push_back(64'hdeadaaaa);
        issue(0, 0, 1, 32'h0, 32'habac, 32'h0, 4'h0);
        @(negedge CLK);
        check("fetch_latency", {M_AXI_ARVALID, M_AXI_ARADDR}, {1'b1, 32'habac});
        drain("fetch");
        repeat (2) @(negedge CLK);
        check("fetch_hold", {instruction_valid, instruction}, {1'b0, 32'hdeadaaaa});
        @(posedge CLK);
        #1;

        sb[QAR].push_back({29'd0, 3'b000, 32'h100});
        sb[QOP].push_back(64'h12345678);
        issue(0, 1, 0, 32'h100, 32'h0, 32'h0, 4'h0);
        drain("load");

        aw_delay = 2;
        sb[QW].push_back({28'd0, 4'b0011, 32'h0badf00d});
        sb[QAW].push_back({29'd0, 3'b000, 32'h200});
        sb[QOP].push_back(64'h12345678);
        issue(1, 0, 0, 32'h200, 32'h0, 32'h0badf00d, 4'b0011);
        for (int i = 0; i < 10 && M_AXI_WVALID; i++) @(negedge CLK);
        check("store_skew", {M_AXI_WVALID, M_AXI_AWVALID}, 2'b01);
        check("store_awprot", M_AXI_AWPROT, 3'b000);
        drain("store");
        aw_delay = 0;

        sb[QAR].push_back({29'd0, 3'b000, 32'h104});
        sb[QAR].push_back({29'd0, FPROT, 32'h3000});
        sb[QOP].push_back(64'hc0de0104);
        sb[QINS].push_back(64'hc0de3000);
        addr = 32'h104;
        pc = 32'h3000;
        read_enable = 1'b1;
        pc_valid = 1'b1;
        @(posedge CLK);
        #1;
        read_enable = 1'b0;
        for (int i = 0; i < 40 && !instruction_valid; i++) @(negedge CLK);
        pc_valid = 1'b0;
        check("contention_fetch_done", instruction_valid, 1'b1);
        drain("contention");

        ar_delay = 5;
        sb[QAR].push_back({29'd0, 3'b000, 32'h108});
        sb[QOP].push_back(64'hc0de0108);
        issue(0, 1, 0, 32'h108, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("stall_stable", {M_AXI_ARVALID, M_AXI_ARREADY, instruction_valid, operation_valid, M_AXI_ARADDR},
                  {4'b1000, 32'h108});
        end
        drain("stall");
        ar_delay = 0;

        r_stall = 1'b1;
        sb[QAR].push_back({29'd0, FPROT, 32'h4000});
        issue(0, 0, 1, 32'h0, 32'h4000, 32'h0, 4'h0);
        repeat (3) @(posedge CLK);
        #1;
        check("midread_rready", M_AXI_RREADY, 1'b1);
        RSTn = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("midreset_handshakes", {M_AXI_RREADY, M_AXI_ARVALID, M_AXI_BREADY}, 3'b000);
        check("midreset_araddr", M_AXI_ARADDR, 32'h0);
        check("midreset_data", {instruction, read_data}, 64'h0);
        check("midreset_pulses", {instruction_valid, operation_valid}, 2'b00);
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        r_stall = 1'b0;
        check("midreset_sb", 64'(total()), 64'd0);

        sb[QAR].push_back({29'd0, FPROT, 32'habac});
        sb[QINS].push_back(64'hdeadaaaa);
        issue(0, 0, 1, 32'h0, 32'habac, 32'h0, 4'h0);
        drain("refetch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
